// File: rtl/whack_pkg.sv
// Shared constants for the whack-a-mole datapath (button conditioner, game core,
// mole generator).
package whack_pkg;

  localparam int N_BTN            = 4;
  localparam int BTN_IDX_W        = 2;
  localparam int DEFAULT_DEBOUNCE = 4;

  typedef logic [N_BTN-1:0]     btn_vec_t;
  typedef logic [BTN_IDX_W-1:0] btn_idx_t;

endpackage

// File: rtl/whack_button_conditioner_if.sv
// Button-side bus of the conditioner: raw levels in, debounced levels, press
// pulses and the encoded hit out.
interface whack_button_conditioner_if;
  import whack_pkg::*;

  btn_vec_t btn_raw;
  btn_vec_t held;
  btn_vec_t press;
  logic     press_valid;
  btn_idx_t press_code;
  logic     multi_press;

  // The master side owns the buttons; the slave is the conditioner.
  modport master (
    output btn_raw,
    input  held, press, press_valid, press_code, multi_press
  );

  modport slave (
    input  btn_raw,
    output held, press, press_valid, press_code, multi_press
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, agreement counter, debounced level
// and a single-cycle pulse on each debounced rising edge.
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic press
);

  localparam int              CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses <= so all flops update from the values
  // present before the edge; blocking assignments would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      held  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == held) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        held  <= sync2;
        cnt   <= '0;
        press <= sync2;  // only a 0->1 flip raises the pulse
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/whack_button_conditioner.sv
// Four-channel button front end: per-channel debounce plus a popcount-checked
// encoder so the game core sees one clean hit per physical press.
module whack_button_conditioner
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic                        clk,
  input  logic                        rst,
  whack_button_conditioner_if.slave   bus
);

  localparam int POP_W = $clog2(N_BTN + 1);

  btn_vec_t   held_w;
  btn_vec_t   press_w;
  logic [POP_W-1:0] pop;
  btn_idx_t   idx;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.btn_raw[i]),
      .held (held_w[i]),
      .press(press_w[i])
    );
  end

  // NOTE: defaults at the top of the block keep every path assigned, so no
  // latch is inferred for pop/idx.
  always_comb begin
    pop = '0;
    idx = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (press_w[i]) begin
        pop = pop + POP_W'(1);
        idx = BTN_IDX_W'(i);
      end
    end
  end

  assign bus.held        = held_w;
  assign bus.press       = press_w;
  assign bus.press_valid = (pop == POP_W'(1));
  assign bus.multi_press = (pop >= POP_W'(2));
  assign bus.press_code  = (pop == POP_W'(1)) ? idx : '0;

endmodule

// File: tb/tb_whack_button_conditioner.sv
// Directed plus randomized bench for whack_button_conditioner against a
// behavioural model built from delayed samples and run lengths.
module tb_whack_button_conditioner;
  import whack_pkg::*;

  localparam int D = DEFAULT_DEBOUNCE;

  logic clk;
  logic rst;
  whack_button_conditioner_if bus ();

  whack_button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference: the counter judges the raw level from two edges ago;
  // the debounced level follows once D consecutive judged samples disagree.
  btn_vec_t dly0, dly1, m_held, m_press;
  int       run [N_BTN];

  int press_cnt [N_BTN];
  int fall_cnt  [N_BTN];
  int multi_cnt;
  int valid_cnt;
  int last_code;
  btn_vec_t prev_held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input btn_vec_t raw);
    btn_vec_t sample;
    if (r) begin
      dly0 = '0; dly1 = '0; m_held = '0; m_press = '0;
      for (int i = 0; i < N_BTN; i++) run[i] = 0;
    end else begin
      sample  = dly1;
      dly1    = dly0;
      dly0    = raw;
      m_press = '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (sample[i] != m_held[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_held[i]  = sample[i];
            m_press[i] = sample[i];
            run[i]     = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    int       pc;
    btn_idx_t exp_code;
    pc       = $countones(m_press);
    exp_code = '0;
    if (pc == 1)
      for (int i = 0; i < N_BTN; i++)
        if (m_press[i]) exp_code = btn_idx_t'(i);
    check("held",        32'(bus.held),        32'(m_held));
    check("press",       32'(bus.press),       32'(m_press));
    check("press_valid", 32'(bus.press_valid), 32'(pc == 1));
    check("press_code",  32'(bus.press_code),  32'(exp_code));
    check("multi_press", 32'(bus.multi_press), 32'(pc >= 2));
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N_BTN; i++) begin
      press_cnt[i] = 0;
      fall_cnt[i]  = 0;
    end
    multi_cnt = 0;
    valid_cnt = 0;
    last_code = -1;
  endtask

  task automatic step(input logic r, input btn_vec_t raw);
    rst         = r;
    bus.btn_raw = raw;
    prev_held   = bus.held;
    @(posedge clk);
    model_edge(r, raw);
    #1;
    compare_all();
    for (int i = 0; i < N_BTN; i++) begin
      if (bus.press[i] === 1'b1) press_cnt[i]++;
      if (prev_held[i] === 1'b1 && bus.held[i] === 1'b0) fall_cnt[i]++;
    end
    if (bus.multi_press === 1'b1) multi_cnt++;
    if (bus.press_valid === 1'b1) begin
      valid_cnt++;
      last_code = int'(bus.press_code);
    end
  endtask

  initial begin
    logic [8:0] bounce_on;
    logic [5:0] bounce_off;
    btn_vec_t   lvl;
    int         dur [N_BTN];

    rst         = 1'b1;
    bus.btn_raw = '0;
    clear_counts();

    // Reset then idle.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000);
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0000);
    check("idle_presses", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);

    // Clean press on button 1: pulse after edge 5, held drops 6 edges after release.
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0001);
      check("clean_press_timing", 32'(bus.press[0]), 32'(i == 5));
    end
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 4'b0000);
      check("clean_release_timing", 32'(bus.held[0]), 32'(j < 5));
    end
    check("clean_press_count", 32'(press_cnt[0]), 32'd1);
    check("clean_valid_count", 32'(valid_cnt), 32'd1);
    check("clean_code", 32'(last_code), 32'd0);

    // Glitch of 3 samples rejected, 4 samples accepted.
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0000);
    check("glitch3_presses", 32'(press_cnt[2]), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0100);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0000);
    check("glitch4_presses", 32'(press_cnt[2]), 32'd1);
    check("glitch4_code", 32'(last_code), 32'd2);

    // Bouncy press and release on button 2.
    clear_counts();
    bounce_on  = 9'b1_1110_1101;  // applied LSB first: 1,0,1,1,0,1,1,1,1
    bounce_off = 6'b00_0010;      // applied LSB first: 0,1,0,0,0,0
    for (int i = 0; i < 9; i++) step(1'b0, {2'b00, bounce_on[i], 1'b0});
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0010);
    check("bounce_press_count", 32'(press_cnt[1]), 32'd1);
    check("bounce_code", 32'(last_code), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, {2'b00, bounce_off[i], 1'b0});
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000);
    check("bounce_release_press", 32'(press_cnt[1]), 32'd1);
    check("bounce_release_falls", 32'(fall_cnt[1]), 32'd1);

    // Simultaneous press on buttons 1 and 4.
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1001);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0000);
    check("simul_multi_count", 32'(multi_cnt), 32'd1);
    check("simul_valid_count", 32'(valid_cnt), 32'd0);
    check("simul_press0", 32'(press_cnt[0]), 32'd1);
    check("simul_press3", 32'(press_cnt[3]), 32'd1);

    // Reset mid-debounce with button 4 held through it.
    clear_counts();
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1000);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b1000);
    check("rst_mid_no_early", 32'(press_cnt[3]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b1000);
      check("rst_mid_timing", 32'(bus.press[3]), 32'(k == 5));
    end
    check("rst_mid_count", 32'(press_cnt[3]), 32'd1);
    check("rst_mid_code", 32'(last_code), 32'd3);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);

    // Randomized levels with random hold times and occasional resets.
    lvl = '0;
    for (int i = 0; i < N_BTN; i++) dur[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (dur[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          dur[i] = int'($urandom_range(1, 8));
        end
        dur[i]--;
      end
      step(($urandom_range(0, 99) == 0), lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
